// File: rtl/xfer_seq_pkg.sv
// Shared types for the register-transfer sequencer: FSM states, 3-bit register
// codes and the active-low select decoder used by the strobe drivers.
package xfer_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_CLEAR = 3'd2,
    S_GAP   = 3'd3,
    S_XFER  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [2:0] NONE = 3'd0;
  localparam logic [2:0] A    = 3'd1;
  localparam logic [2:0] L    = 3'd2;
  localparam logic [2:0] Q    = 3'd3;
  localparam logic [2:0] Z    = 3'd4;
  localparam logic [2:0] B    = 3'd5;
  localparam logic [2:0] G    = 3'd6;
  localparam logic [2:0] U    = 3'd7;

  localparam logic [7:0] SEL_IDLE = 8'hFF;

  // Code NONE never drives a select, so bit 0 stays high.
  function automatic logic [7:0] sel_decode(input logic [2:0] code);
    logic [7:0] sel;
    sel = SEL_IDLE;
    if (code != NONE) begin
      sel[code] = 1'b0;
    end else begin
      sel = SEL_IDLE;
    end
    return sel;
  endfunction

endpackage

// File: rtl/xfer_arbiter.sv
// One-hot requester arbiter for xfer_sequencer. Fixed priority (index 0 highest)
// by default; XFER_SEQ_RR_EN selects round-robin with a last-granted pointer.
module xfer_arbiter
#(
  parameter int N_REQ = 3
) (
`ifdef XFER_SEQ_RR_EN
  input  logic             clk,
  input  logic             rst,
  input  logic             take,
`endif
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic             any
);

`ifdef XFER_SEQ_RR_EN
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IW-1:0] last_r;
  logic [IW-1:0] win;

  // Search starts one past the last winner and wraps around.
  always_comb begin
    int c;
    logic [IW-1:0] ci;
    logic hit;
    grant = '0;
    win   = last_r;
    any   = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      c   = (int'(last_r) + k) % N_REQ;
      ci  = IW'(c);
      hit = !any && req[ci];
      if (hit) begin
        grant[ci] = 1'b1;
        win       = ci;
        any       = 1'b1;
      end else begin
        win = win;
      end
    end
  end

  // Pointer reset makes the first grant after reset go to index 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_r <= IW'(N_REQ - 1);
    end else if (take) begin
      last_r <= win;
    end
  end
`else
  // Lowest set bit wins.
  always_comb begin
    grant = req & (~req + {{(N_REQ-1){1'b0}}, 1'b1});
    any   = |req;
  end
`endif

endmodule

// File: rtl/xfer_sequencer.sv
// Shares the register-transfer datapath between requesters and sequences the
// CT/WT/RT strobes and R/W selects (clear, break, transfer). Option: XFER_SEQ_RR_EN.
module xfer_sequencer
  import xfer_seq_pkg::*;
#(
  parameter int N_REQ    = 3,
  parameter int CLR_CYC  = 1,
  parameter int XFER_CYC = 2
) (
  input  logic               SIM_CLK,
  input  logic               SIM_RST,
  input  logic [N_REQ-1:0]   req,
  input  logic [3*N_REQ-1:0] req_src,
  input  logic [3*N_REQ-1:0] req_dst,
  input  logic               inhibit,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic               err,
  output logic               busy,
  output logic               RT_n,
  output logic               WT_n,
  output logic               CT_n,
  output logic [7:0]         R_n,
  output logic [7:0]         W_n
);

  localparam logic [3:0] CLR_LOAD  = 4'(CLR_CYC - 1);
  localparam logic [3:0] XFER_LOAD = 4'(XFER_CYC - 1);

  state_t           state;
  logic [3:0]       cnt;
  logic [2:0]       src_r;
  logic [2:0]       dst_r;
  logic [2:0]       src_sel;
  logic [2:0]       dst_sel;
  logic [N_REQ-1:0] arb_gnt;
  logic             arb_any;

`ifdef XFER_SEQ_RR_EN
  logic take;
  assign take = (state == S_IDLE) && !inhibit && arb_any;

  xfer_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk   (SIM_CLK),
    .rst   (SIM_RST),
    .take  (take),
    .req   (req),
    .grant (arb_gnt),
    .any   (arb_any)
  );
`else
  xfer_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req   (req),
    .grant (arb_gnt),
    .any   (arb_any)
  );
`endif

  // Operand mux: the one-hot grant picks the winner's src/dst slices.
  always_comb begin
    src_sel = NONE;
    dst_sel = NONE;
    for (int i = 0; i < N_REQ; i++) begin
      src_sel = src_sel | (req_src[3*i +: 3] & {3{arb_gnt[i]}});
      dst_sel = dst_sel | (req_dst[3*i +: 3] & {3{arb_gnt[i]}});
    end
  end

  // Phase FSM; outputs are set on entry to each state so they are all registered.
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      src_r <= NONE;
      dst_r <= NONE;
      gnt   <= '0;
      done  <= '0;
      err   <= 1'b0;
      busy  <= 1'b0;
      RT_n  <= 1'b1;
      WT_n  <= 1'b1;
      CT_n  <= 1'b1;
      R_n   <= SEL_IDLE;
      W_n   <= SEL_IDLE;
    end else begin
      done <= '0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!inhibit && arb_any) begin
            state <= S_GRANT;
            gnt   <= arb_gnt;
            src_r <= src_sel;
            dst_r <= dst_sel;
            busy  <= 1'b1;
          end else begin
            gnt  <= '0;
            busy <= 1'b0;
          end
        end
        S_GRANT: begin
          if (dst_r == NONE) begin
            state <= S_DONE;
            done  <= gnt;
            err   <= 1'b1;
          end else begin
            state <= S_CLEAR;
            cnt   <= CLR_LOAD;
            CT_n  <= 1'b0;
            W_n   <= sel_decode(dst_r);
          end
        end
        S_CLEAR: begin
          if (cnt == 4'd0) begin
            state <= S_GAP;
            CT_n  <= 1'b1;
            W_n   <= SEL_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_GAP: begin
          state <= S_XFER;
          cnt   <= XFER_LOAD;
          WT_n  <= 1'b0;
          W_n   <= sel_decode(dst_r);
          // A clear-only transfer leaves the read side idle.
          if (src_r != NONE) begin
            RT_n <= 1'b0;
            R_n  <= sel_decode(src_r);
          end else begin
            RT_n <= 1'b1;
            R_n  <= SEL_IDLE;
          end
        end
        S_XFER: begin
          if (cnt == 4'd0) begin
            state <= S_DONE;
            done  <= gnt;
            RT_n  <= 1'b1;
            WT_n  <= 1'b1;
            R_n   <= SEL_IDLE;
            W_n   <= SEL_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
          RT_n  <= 1'b1;
          WT_n  <= 1'b1;
          CT_n  <= 1'b1;
          R_n   <= SEL_IDLE;
          W_n   <= SEL_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xfer_sequencer.sv
// Randomized scoreboard bench for xfer_sequencer: a transaction-level model
// predicts each grant and the per-phase output pattern; a monitor compares.
module tb_xfer_sequencer;

  localparam int N_REQ = 3;
  localparam int CLR   = 1;
  localparam int XFER  = 2;
  localparam int VW    = 2*N_REQ + 21;
  localparam int BIG   = 1 << 30;

  typedef struct {
    int         idx;
    logic [2:0] src;
    logic [2:0] dst;
  } txn_t;

  logic               SIM_CLK = 1'b0;
  logic               SIM_RST = 1'b1;
  logic [N_REQ-1:0]   req     = '0;
  logic [3*N_REQ-1:0] req_src = '0;
  logic [3*N_REQ-1:0] req_dst = '0;
  logic               inhibit = 1'b0;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   done;
  logic               err;
  logic               busy;
  logic               RT_n;
  logic               WT_n;
  logic               CT_n;
  logic [7:0]         R_n;
  logic [7:0]         W_n;

  int   cyc       = 0;
  int   arb_k     = BIG;
  int   next_arb  = BIG;
  int   vectors   = 0;
  int   miscompares = 0;
  txn_t q[$];
`ifdef XFER_SEQ_RR_EN
  int   last_g    = N_REQ - 1;
`endif

  xfer_sequencer #(.N_REQ(N_REQ), .CLR_CYC(CLR), .XFER_CYC(XFER)) dut (
    .SIM_CLK (SIM_CLK),
    .SIM_RST (SIM_RST),
    .req     (req),
    .req_src (req_src),
    .req_dst (req_dst),
    .inhibit (inhibit),
    .gnt     (gnt),
    .done    (done),
    .err     (err),
    .busy    (busy),
    .RT_n    (RT_n),
    .WT_n    (WT_n),
    .CT_n    (CT_n),
    .R_n     (R_n),
    .W_n     (W_n)
  );

  always #5 SIM_CLK = ~SIM_CLK;
  always @(posedge SIM_CLK) cyc <= cyc + 1;

  function automatic logic [7:0] sel(input logic [2:0] code);
    return ~(8'h01 << code) | 8'h01;
  endfunction

  localparam logic [VW-1:0] IDLE_V = {{(2*N_REQ){1'b0}}, 1'b0, 1'b0, 3'b111, 8'hFF, 8'hFF};

  function automatic int last_phase(input txn_t t);
    return (t.dst == 3'd0) ? 2 : 3 + CLR + XFER;
  endfunction

  // Expected outputs p cycles after the arbitration cycle of transaction t.
  function automatic logic [VW-1:0] busy_vec(input txn_t t, input int p);
    logic [N_REQ-1:0] g;
    logic dn, er, rt, wt, ct;
    logic [7:0] r, w;
    g  = N_REQ'(1) << t.idx;
    dn = 1'b0; er = 1'b0; rt = 1'b1; wt = 1'b1; ct = 1'b1;
    r  = 8'hFF; w = 8'hFF;
    if (t.dst == 3'd0) begin
      if (p == 2) begin dn = 1'b1; er = 1'b1; end
    end else if (p >= 2 && p <= 1 + CLR) begin
      ct = 1'b0; w = sel(t.dst);
    end else if (p >= 3 + CLR && p <= 2 + CLR + XFER) begin
      wt = 1'b0; w = sel(t.dst);
      if (t.src != 3'd0) begin rt = 1'b0; r = sel(t.src); end
    end else if (p == 3 + CLR + XFER) begin
      dn = 1'b1;
    end
    return {g, (dn ? g : {N_REQ{1'b0}}), er, 1'b1, rt, wt, ct, r, w};
  endfunction

  // Monitor: compare every cycle; retire the transaction at its DONE cycle.
  always @(negedge SIM_CLK) begin : mon
    logic [VW-1:0] e, a;
    int p;
    bit in_txn;
    a      = {gnt, done, err, busy, RT_n, WT_n, CT_n, R_n, W_n};
    in_txn = (cyc > arb_k) && (cyc < next_arb) && (q.size() > 0);
    p      = cyc - arb_k;
    e      = in_txn ? busy_vec(q[0], p) : IDLE_V;
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL outputs cyc=%0d phase=%0d got=%h expected=%h", cyc, in_txn ? p : 0, a, e);
    end
    if (in_txn && p == last_phase(q[0])) void'(q.pop_front());
  end

  // Reference arbitration at an IDLE cycle, from the inputs just driven.
  task automatic model_arb();
    int w;
    w = -1;
    if (!inhibit && req != '0) begin
`ifdef XFER_SEQ_RR_EN
      for (int k = 1; k <= N_REQ; k++) begin
        int c;
        c = (last_g + k) % N_REQ;
        if (w < 0 && req[c]) w = c;
      end
      last_g = w;
`else
      for (int k = N_REQ - 1; k >= 0; k--) if (req[k]) w = k;
`endif
    end
    if (w >= 0) begin
      txn_t t;
      t.idx = w;
      t.src = req_src[3*w +: 3];
      t.dst = req_dst[3*w +: 3];
      q.push_back(t);
      arb_k    = cyc;
      next_arb = cyc + ((t.dst == 3'd0) ? 3 : 4 + CLR + XFER);
    end else begin
      next_arb = cyc + 1;
    end
  endtask

  task automatic step(input logic rst, input logic [N_REQ-1:0] r,
                      input logic [3*N_REQ-1:0] s, input logic [3*N_REQ-1:0] d,
                      input logic inh);
    @(negedge SIM_CLK);
    #1;
    SIM_RST = rst; req = r; req_src = s; req_dst = d; inhibit = inh;
    if (rst) begin
      q.delete();
      arb_k    = BIG;
      next_arb = BIG;
`ifdef XFER_SEQ_RR_EN
      last_g = N_REQ - 1;
`endif
    end else begin
      if (next_arb == BIG) begin next_arb = cyc; arb_k = cyc; end
      if (cyc == next_arb) model_arb();
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0);
  endtask

  // Hold a request until the model grants it (bounded), then drop it.
  task automatic xact(input logic [N_REQ-1:0] r, input logic [3*N_REQ-1:0] s,
                      input logic [3*N_REQ-1:0] d);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      step(1'b0, r, s, d, 1'b0);
      if (arb_k == cyc) got = 1'b1;
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL grant_wait req=%b got=no-grant expected=grant within 40 cycles", r);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) step(1'b1, '0, '0, '0, 1'b0);
    // Contention straight out of reset: three transactions with req=111.
    for (int i = 0; i < 21; i++) step(1'b0, 3'b111, {3'd1, 3'd2, 3'd3}, {3'd4, 3'd7, 3'd6}, 1'b0);
    idle(3);
    // Basic A -> B on requester 1.
    xact(3'b010, {3'd0, 3'd1, 3'd0}, {3'd0, 3'd5, 3'd0});
    idle(7);
    // Clear-only, invalid destination, src = dst.
    xact(3'b001, {3'd0, 3'd0, 3'd0}, {3'd0, 3'd0, 3'd3});
    idle(7);
    xact(3'b001, {3'd0, 3'd0, 3'd2}, {3'd0, 3'd0, 3'd0});
    idle(3);
    xact(3'b100, {3'd6, 3'd0, 3'd0}, {3'd6, 3'd0, 3'd0});
    idle(7);
    // Inhibit raised in CLEAR with req[2] pending; released later.
    xact(3'b010, {3'd0, 3'd7, 3'd0}, {3'd0, 3'd2, 3'd0});
    idle(1);
    for (int i = 0; i < 12; i++) step(1'b0, 3'b100, {3'd4, 3'd0, 3'd0}, {3'd1, 3'd0, 3'd0}, 1'b1);
    xact(3'b100, {3'd4, 3'd0, 3'd0}, {3'd1, 3'd0, 3'd0});
    idle(7);
    // Reset pulse during XFER: transaction abandoned, no done.
    xact(3'b001, {3'd0, 3'd0, 3'd1}, {3'd0, 3'd0, 3'd2});
    idle(3);
    step(1'b1, '0, '0, '0, 1'b0);
    idle(4);
    // Randomized bursts with occasional inhibit and reset.
    for (int b = 0; b < 80; b++) begin
      logic [N_REQ-1:0]   r;
      logic [3*N_REQ-1:0] s, d;
      logic               inh;
      int                 hold;
      r    = N_REQ'($urandom);
      s    = (3*N_REQ)'($urandom);
      d    = (3*N_REQ)'($urandom);
      inh  = ($urandom_range(0, 5) == 0);
      hold = $urandom_range(1, 8);
      for (int i = 0; i < hold; i++) step(1'b0, r, s, d, inh);
      if ($urandom_range(0, 30) == 0) step(1'b1, r, s, d, inh);
    end
    idle(10);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
